uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART transmit path for the core's console output: buffers bytes written by the CPU's data-memory I/O port (`uart_out` / `uart_wrreq`) in a small FIFO and serializes them onto the board TX pin as 8N1 frames. It is the consumer end of the CPU's UART write interface and sits beside the receive FIFO that feeds `uart_in` / `uart_rdreq` / `uart_empty`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is ≥ 2.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes.
- `clk`  in  1  system clock. This is the only clock; all logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wrreq`  in  1  push request from the CPU. Sampled on the rising edge of `clk`.
- `data`  in  8  byte to push. Sampled with `wrreq`.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes. Registered.
- `empty`  out  1  FIFO holds 0 bytes. Registered.
- `busy`  out  1  a frame is in progress, or the FIFO is non-empty.
- `tx`  out  1  serial line. Idles high. Registered, glitch-free.

## Operation
- **Push:** when `wrreq` is high and `full` is low, `data` is stored at the write pointer. When `wrreq` is high and `full` is high, the byte is silently dropped and no state changes. The CPU polls `full` before writing.
- **Pointers:** DEPTH_LOG2+1 bits wide with wrap bit. Occupancy = wr − rd, modulo 2^(DEPTH_LOG2+1). `full` and `empty` are updated on the same edge as the push or pop that changes them.
- **Push and pop in the same cycle:** occupancy is unchanged. A push into a full FIFO is still dropped, even if a pop happens on the same edge.
- **Serializer FSM:**
  - IDLE: `tx`=1. If `empty`=0, pop a byte into `shift[7:0]`, set `tx`<=0, clear the bit counter and the bit index, and go to START.
  - START: hold `tx`=0 for CLKS_PER_BIT cycles, then set `tx`<=`shift[0]` and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. Bits go out LSB first and the shift register shifts right. After bit index 7 completes, set `tx`<=1 and go to STOP.
  - STOP: hold `tx`=1 for CLKS_PER_BIT cycles. On the final cycle:
    - if `empty`=0, pop, set `tx`<=0 and go to START. This gives back-to-back frames with no idle gap.
    - otherwise go to IDLE.
- **Counters:** the bit-period counter is sized to hold CLKS_PER_BIT−1 and counts 0..CLKS_PER_BIT−1. The bit index is 3 bits.
- **busy:** `(state != IDLE) | ~empty`.
- **Reset** (any time, including mid-frame) has these values on the next edge:
  - `tx`=1, state=IDLE
  - pointers=0, `empty`=1, `full`=0, `busy`=0
  - A partial frame is abandoned, and FIFO contents are discarded.

## Timing
- **Reset values:** `tx`=1, `full`=0, `empty`=1, `busy`=0.
- **Write to start-bit latency:** a push sampled at edge k into an idle, empty block gives `empty`=0 after edge k. The pop happens at edge k+1, and `tx` falls after edge k+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles, measured from `tx` falling to the next possible falling edge (back-to-back) or to the return to IDLE.
- **Pop timing:** the pop occurs on the edge `tx` falls. A slot therefore frees one start-bit period before that byte is sent.
- **FIFO read:** the read is combinational from the storage array at the read pointer. The storage itself is a register array, not block RAM.

## Structure
- Shared header `uart_defs.vh` holds:
  - FSM state encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Default CLKS_PER_BIT.
  - The same header is reused by the receive side.
- Sub-module `sync_fifo`:
  - Parameterized by width (8) and DEPTH_LOG2.
  - Ports: `clk`, `reset`, `wrreq`, `data`, `rdreq`, `q`, `full`, `empty`.
  - `uart_tx_fifo` instantiates it and holds the FSM, shift register and counters.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH_LOG2=2.
1. **Single byte:** reset, then push 0x55 at edge 10 → `tx` low from edge 11 for 4 cycles. Data bits are 1,0,1,0,1,0,1,0, each 4 cycles. Stop bit high for 4 cycles. `busy` drops after edge 51 and `empty` stays 1.
2. **Back-to-back:** push 0x00 then 0xFF on consecutive cycles → two frames of 40 cycles each with no idle cycle between. The second start bit begins on the edge immediately after the first stop bit's 4th cycle.
3. **Overflow:** while 0xA0 is transmitting, push 0xA1–0xA5 → `full`=1 after 0xA4, and 0xA5 is dropped. The line shows A0, A1, A2, A3, A4 and then goes idle.
4. **Full plus simultaneous pop:** with `full`=1, push 0x77 on the edge a STOP→START pop occurs → 0x77 is dropped and occupancy goes 4→3.
5. **Reset mid-frame:** assert `reset` during data bit 3 of 0xC3 with 2 bytes queued → after the next edge `tx`=1, `empty`=1, `busy`=0. No further frames appear.
6. **Frame check:** a bench UART receive model sampling at mid-bit decodes a 16-byte random sequence with no framing errors, and its pacing on `full` matches the scoreboard.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: serializer state encodings
// and framing constants. The receive side reuses the same encodings.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with a register-array store and wrap-bit pointers.
// Read data is combinational from the slot at the read pointer.
// full/empty are registered and update on the edge of the push/pop
// that changes them.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] wr_next;
  logic [DEPTH_LOG2:0] rd_next;
  logic [DEPTH_LOG2:0] occ_next;
  logic                push;
  logic                pop;

  // A push into a full FIFO is dropped even if a pop happens on the same edge
  always_comb begin
    push     = wrreq & ~full;
    pop      = rdreq & ~empty;
    wr_next  = wr_ptr + {{DEPTH_LOG2{1'b0}}, push};
    rd_next  = rd_ptr + {{DEPTH_LOG2{1'b0}}, pop};
    occ_next = wr_next - rd_next;
  end

  // Pointer and flag registers; reset discards contents by zeroing pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {(DEPTH_LOG2 + 1){1'b0}};
      rd_ptr <= {(DEPTH_LOG2 + 1){1'b0}};
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (occ_next == DEPTH_CNT);
      empty  <= (occ_next == {(DEPTH_LOG2 + 1){1'b0}});
    end
  end

  // Storage write; the array itself is not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= data;
    end
  end

  assign q = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: CPU bytes are queued in a sync_fifo and sent as 8N1
// frames, LSB first. The pop happens on the edge the start bit begins, and a
// non-empty FIFO at the last stop-bit cycle chains straight into the next
// start bit with no idle gap.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wrreq,
  input  logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic             tx_next;
  logic             rdreq;
  logic [7:0]       q;
  logic             bit_done;

  sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wrreq (wrreq),
    .data  (data),
    .rdreq (rdreq),
    .q     (q),
    .full  (full),
    .empty (empty)
  );

  // Serializer next-state, pop request and next line value
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    tx_next    = tx;
    rdreq      = 1'b0;
    bit_done   = (cnt == LAST_CNT);
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          rdreq      = 1'b1;
          shift_next = q;
          tx_next    = 1'b0;
          cnt_next   = {CNT_W{1'b0}};
          idx_next   = 3'd0;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_next   = {CNT_W{1'b0}};
          tx_next    = shift[0];
          state_next = DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next = {CNT_W{1'b0}};
          if (idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            idx_next   = idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_next = {CNT_W{1'b0}};
          if (!empty) begin
            rdreq      = 1'b1;
            shift_next = q;
            tx_next    = 1'b0;
            idx_next   = 3'd0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Serializer state, counters, shift register and registered line output
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= {CNT_W{1'b0}};
      idx   <= 3'd0;
      shift <= 8'd0;
      tx    <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
      tx    <= tx_next;
    end
  end

  assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH_LOG2=2.
// Outputs are sampled 1 time unit after each rising edge; a "position c"
// means c cycles after the edge on which tx fell for the current frame.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wrreq;
  logic [7:0] data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DL2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wrreq (wrreq),
    .data  (data),
    .full  (full),
    .empty (empty),
    .busy  (busy),
    .tx    (tx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level at cycle c of an 8N1 frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int c);
    int j;
    j = c / CPB;
    if (j == 0) return 1'b0;
    else if (j <= 8) return b[j-1];
    else return 1'b1;
  endfunction

  // Check tx at positions c0..c1, stepping after each; ends at position c1+1
  task automatic check_frame(input logic [7:0] b, input int c0, input int c1, input string tag);
    for (int c = c0; c <= c1; c++) begin
      chk($sformatf("%s_tx_c%0d", tag, c), {31'd0, tx}, {31'd0, frame_bit(b, c)});
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},  32'd0);
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, "_tx"},    {31'd0, tx},    32'd1);
  endtask

  // Overall time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sb[$];
    logic [7:0] rx_b;
    int occ;
    int sent;
    int rcvd;
    int rx_c;
    int frame_err;
    bit pend;
    bit rx_act;
    bit low_seen;

    reset = 1'b1;
    wrreq = 1'b0;
    data  = 8'd0;
    step();
    step();
    reset = 1'b0;
    chk("rst_tx",    {31'd0, tx},    32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    for (int i = 0; i < 5; i++) step();

    // Scenario 1: single byte 0x55
    data  = 8'h55;
    wrreq = 1'b1;
    step();
    wrreq = 1'b0;
    chk("s1_empty_after_push", {31'd0, empty}, 32'd0);
    chk("s1_busy_after_push",  {31'd0, busy},  32'd1);
    chk("s1_tx_before_pop",    {31'd0, tx},    32'd1);
    step();
    chk("s1_empty_after_pop",  {31'd0, empty}, 32'd1);
    check_frame(8'h55, 0, 10*CPB-1, "s1");
    check_idle("s1_end");

    // Scenario 2: back-to-back 0x00 then 0xFF
    data  = 8'h00;
    wrreq = 1'b1;
    step();
    data  = 8'hFF;
    step();
    wrreq = 1'b0;
    chk("s2_second_queued", {31'd0, empty}, 32'd0);
    check_frame(8'h00, 0, 10*CPB-1, "s2a");
    check_frame(8'hFF, 0, 10*CPB-1, "s2b");
    check_idle("s2_end");

    // Scenario 3: overflow while 0xA0 is on the line
    data  = 8'hA0;
    wrreq = 1'b1;
    step();
    wrreq = 1'b0;
    step();
    chk("s3_start_low", {31'd0, tx}, 32'd0);
    wrreq = 1'b1;
    data = 8'hA1; step();
    data = 8'hA2; step();
    data = 8'hA3; step();
    chk("s3_full_at3", {31'd0, full}, 32'd0);
    data = 8'hA4; step();
    chk("s3_full_at4", {31'd0, full}, 32'd1);
    data = 8'hA5; step();
    wrreq = 1'b0;
    chk("s3_full_after_drop", {31'd0, full}, 32'd1);
    check_frame(8'hA0, 5, 10*CPB-1, "s3_a0");
    check_frame(8'hA1, 0, 10*CPB-1, "s3_a1");
    check_frame(8'hA2, 0, 10*CPB-1, "s3_a2");
    check_frame(8'hA3, 0, 10*CPB-1, "s3_a3");
    check_frame(8'hA4, 0, 10*CPB-1, "s3_a4");
    check_idle("s3_end");

    // Scenario 4: push into a full FIFO on the STOP->START pop edge
    data  = 8'hB0;
    wrreq = 1'b1;
    step();
    wrreq = 1'b0;
    step();
    wrreq = 1'b1;
    data = 8'h71; step();
    data = 8'h72; step();
    data = 8'h73; step();
    data = 8'h74; step();
    wrreq = 1'b0;
    chk("s4_full", {31'd0, full}, 32'd1);
    check_frame(8'hB0, 4, 10*CPB-2, "s4_b0");
    chk("s4_last_stop_tx",   {31'd0, tx},   32'd1);
    chk("s4_last_stop_full", {31'd0, full}, 32'd1);
    data  = 8'h77;
    wrreq = 1'b1;
    step();
    wrreq = 1'b0;
    chk("s4_full_after_pop",  {31'd0, full},  32'd0);
    chk("s4_empty_after_pop", {31'd0, empty}, 32'd0);
    check_frame(8'h71, 0, 10*CPB-1, "s4_71");
    check_frame(8'h72, 0, 10*CPB-1, "s4_72");
    check_frame(8'h73, 0, 10*CPB-1, "s4_73");
    check_frame(8'h74, 0, 10*CPB-1, "s4_74");
    check_idle("s4_end");

    // Scenario 5: reset during data bit 3 of 0xC3 with two bytes queued
    data  = 8'hC3;
    wrreq = 1'b1;
    step();
    data = 8'h11; step();
    data = 8'h22; step();
    wrreq = 1'b0;
    check_frame(8'hC3, 1, 4*CPB, "s5_c3");
    chk("s5_queued", {31'd0, empty}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5_rst_tx",    {31'd0, tx},    32'd1);
    chk("s5_rst_empty", {31'd0, empty}, 32'd1);
    chk("s5_rst_busy",  {31'd0, busy},  32'd0);
    chk("s5_rst_full",  {31'd0, full},  32'd0);
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
      step();
    end
    chk("s5_line_stays_idle", {31'd0, low_seen}, 32'd0);

    // Scenario 6: 16 random bytes paced on full, mid-bit receive model
    occ       = 0;
    sent      = 0;
    rcvd      = 0;
    rx_c      = 0;
    rx_b      = 8'd0;
    frame_err = 0;
    pend      = 1'b0;
    rx_act    = 1'b0;
    for (int cyc = 0; cyc < 3000 && rcvd < 16; cyc++) begin
      if (pend) occ++;
      if (rx_act) begin
        rx_c++;
        if (rx_c == 2) begin
          if (tx !== 1'b0) frame_err++;
        end else if (rx_c >= 6 && rx_c <= 34 && (rx_c % CPB) == 2) begin
          rx_b[(rx_c - 6) / CPB] = tx;
        end else if (rx_c == 38) begin
          if (tx !== 1'b1) frame_err++;
          rx_act = 1'b0;
          rcvd++;
          chk("s6_sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) chk($sformatf("s6_byte%0d", rcvd), {24'd0, rx_b}, {24'd0, sb.pop_front()});
        end
      end else if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_c   = 0;
        occ--;
      end
      chk("s6_full",  {31'd0, full},  {31'd0, occ == DEPTH});
      chk("s6_empty", {31'd0, empty}, {31'd0, occ == 0});
      if (sent < 16 && full == 1'b0) begin
        data  = 8'($urandom_range(0, 255));
        wrreq = 1'b1;
        sb.push_back(data);
        sent++;
        pend = 1'b1;
      end else begin
        wrreq = 1'b0;
        pend  = 1'b0;
      end
      step();
    end
    wrreq = 1'b0;
    chk("s6_sent",       sent,      32'd16);
    chk("s6_received",   rcvd,      32'd16);
    chk("s6_frame_errs", frame_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
